chacha20_poly1305_bus_master: RTL and testbench

- Bus initiator that drives the ChaCha20-Poly1305 register slave over its cs/we/address/512-bit data interface.
- Accepts one job per start pulse: key, nonce, one 512-bit block and a direction bit. Programs the slave, pulses init, polls status, then reads back the result block and the tag.
- Sits between the memory-processing datapath and the crypto slave. Replaces software register sequencing.

---
 rtl/chacha20_poly1305_bus_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_chacha20_poly1305_bus_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_poly1305_bus_master.sv
// chacha20_poly1305_bus_master
// Bus initiator that runs one ChaCha20-Poly1305 job on the register slave:
// programs direction, key, nonce and data, pulses init, polls status and
// reads back the result block and the tag.
// Optional build macro VERSION_CHECK_EN: read and compare the slave version
// register before any write is issued.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | waiting for start; job inputs latched on acceptance
// LOAD        | busy raised; first access being set up
// VER_REQ     | read of 0x00 on the bus (VERSION_CHECK_EN only)
// VER_CHK     | version word on read_data is compared (VERSION_CHECK_EN only)
// ENC         | write 0x0a (direction bit)
// KEY         | writes 0x10..0x17, word_idx selects the word
// NONCE       | writes 0x20..0x22, word_idx selects the word
// DATA        | write 0x30 (whole block)
// INIT_SET    | write 0x08 = 1
// INIT_CLR    | write 0x08 = 0
// POLL_REQ    | read 0x09
// POLL_CHK    | status on read_data is inspected
// RD_DATA_REQ | read 0x30
// RD_DATA_CAP | result captured
// RD_TAG_REQ  | read 0x40
// RD_TAG_CAP  | tag captured
// FINISH      | done pulse; busy still high
//
// Bus outputs are registered: the value driven in a state is loaded on the
// edge that enters it, so read_data for a *_REQ read is present in the
// following *_CHK / *_CAP state.

module chacha20_poly1305_bus_master #(
    parameter int TIMEOUT_POLLS = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         encdec,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [511:0] block_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [511:0] result,
    output logic [127:0] tag,
    output logic         tag_ok,
    output logic         cs,
    output logic         we,
    output logic [7:0]   address,
    output logic [511:0] write_data,
    input  logic [511:0] read_data
);

    typedef enum logic [4:0] {
        IDLE,
        LOAD,
        VER_REQ,
        VER_CHK,
        ENC,
        KEY,
        NONCE,
        DATA,
        INIT_SET,
        INIT_CLR,
        POLL_REQ,
        POLL_CHK,
        RD_DATA_REQ,
        RD_DATA_CAP,
        RD_TAG_REQ,
        RD_TAG_CAP,
        FINISH
    } state_t;

    localparam logic [7:0]  ADDR_INIT   = 8'h08;
    localparam logic [7:0]  ADDR_STATUS = 8'h09;
    localparam logic [7:0]  ADDR_ENC    = 8'h0a;
    localparam logic [7:0]  ADDR_KEY0   = 8'h10;
    localparam logic [7:0]  ADDR_NONCE0 = 8'h20;
    localparam logic [7:0]  ADDR_DATA   = 8'h30;
    localparam logic [7:0]  ADDR_TAG    = 8'h40;
    localparam logic [15:0] POLL_LIMIT  = 16'(TIMEOUT_POLLS);
`ifdef VERSION_CHECK_EN
    localparam logic [7:0]   ADDR_VERSION = 8'h00;
    localparam logic [511:0] VERSION_ID   = 512'h6332307031333035302e3031;
`endif

    state_t         state;
    logic [255:0]   key_sh;     // word 0 always sits in [255:224]
    logic [95:0]    nonce_sh;   // word 0 always sits in [31:0]
    logic [511:0]   block_r;
    logic           encdec_r;
    logic [2:0]     word_idx;
    logic [15:0]    poll_cnt;

    // Job sequencer: state, bus outputs and captured results in one register block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cs         <= 1'b0;
            we         <= 1'b0;
            address    <= '0;
            write_data <= '0;
            result     <= '0;
            tag        <= '0;
            tag_ok     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            key_sh     <= '0;
            nonce_sh   <= '0;
            block_r    <= '0;
            encdec_r   <= 1'b0;
            word_idx   <= '0;
            poll_cnt   <= '0;
        end else begin
            cs         <= 1'b0;
            we         <= 1'b0;
            write_data <= '0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_sh   <= key;
                        nonce_sh <= nonce;
                        block_r  <= block_in;
                        encdec_r <= encdec;
                        poll_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
`ifdef VERSION_CHECK_EN
                    cs      <= 1'b1;
                    address <= ADDR_VERSION;
                    state   <= VER_REQ;
`else
                    cs         <= 1'b1;
                    we         <= 1'b1;
                    address    <= ADDR_ENC;
                    write_data <= {511'b0, encdec_r};
                    state      <= ENC;
`endif
                end
`ifdef VERSION_CHECK_EN
                VER_REQ: state <= VER_CHK;
                VER_CHK: begin
                    if (read_data == VERSION_ID) begin
                        cs         <= 1'b1;
                        we         <= 1'b1;
                        address    <= ADDR_ENC;
                        write_data <= {511'b0, encdec_r};
                        state      <= ENC;
                    end else begin
                        // wrong slave: abort before touching any register
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
`endif
                ENC: begin
                    cs         <= 1'b1;
                    we         <= 1'b1;
                    address    <= ADDR_KEY0;
                    write_data <= {480'b0, key_sh[255:224]};
                    key_sh     <= key_sh << 32;
                    word_idx   <= '0;
                    state      <= KEY;
                end
                KEY: begin
                    cs <= 1'b1;
                    we <= 1'b1;
                    if (word_idx == 3'd7) begin
                        address    <= ADDR_NONCE0;
                        write_data <= {480'b0, nonce_sh[31:0]};
                        nonce_sh   <= nonce_sh >> 32;
                        word_idx   <= '0;
                        state      <= NONCE;
                    end else begin
                        address    <= address + 8'd1;
                        write_data <= {480'b0, key_sh[255:224]};
                        key_sh     <= key_sh << 32;
                        word_idx   <= word_idx + 3'd1;
                    end
                end
                NONCE: begin
                    cs <= 1'b1;
                    we <= 1'b1;
                    if (word_idx == 3'd2) begin
                        address    <= ADDR_DATA;
                        write_data <= block_r;
                        state      <= DATA;
                    end else begin
                        address    <= address + 8'd1;
                        write_data <= {480'b0, nonce_sh[31:0]};
                        nonce_sh   <= nonce_sh >> 32;
                        word_idx   <= word_idx + 3'd1;
                    end
                end
                DATA: begin
                    cs         <= 1'b1;
                    we         <= 1'b1;
                    address    <= ADDR_INIT;
                    write_data <= 512'd1;
                    state      <= INIT_SET;
                end
                INIT_SET: begin
                    cs      <= 1'b1;
                    we      <= 1'b1;
                    address <= ADDR_INIT;
                    state   <= INIT_CLR;
                end
                INIT_CLR: begin
                    cs      <= 1'b1;
                    address <= ADDR_STATUS;
                    state   <= POLL_REQ;
                end
                POLL_REQ: state <= POLL_CHK;
                POLL_CHK: begin
                    if (read_data[1]) begin
                        tag_ok  <= read_data[2];
                        cs      <= 1'b1;
                        address <= ADDR_DATA;
                        state   <= RD_DATA_REQ;
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                        if (poll_cnt + 16'd1 == POLL_LIMIT) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            cs      <= 1'b1;
                            address <= ADDR_STATUS;
                            state   <= POLL_REQ;
                        end
                    end
                end
                RD_DATA_REQ: state <= RD_DATA_CAP;
                RD_DATA_CAP: begin
                    result  <= read_data;
                    cs      <= 1'b1;
                    address <= ADDR_TAG;
                    state   <= RD_TAG_REQ;
                end
                RD_TAG_REQ: state <= RD_TAG_CAP;
                RD_TAG_CAP: begin
                    tag   <= read_data[127:0];
                    err   <= 1'b0;
                    done  <= 1'b1;
                    state <= FINISH;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha20_poly1305_bus_master.sv
// Bench for chacha20_poly1305_bus_master: behavioural register slave plus a
// job-level reference model (expected write trace, read list, latency and
// results derived from the job inputs).

module tb_chacha20_poly1305_bus_master;

    localparam int TMO = 6;
`ifdef VERSION_CHECK_EN
    localparam int VX = 2;
`else
    localparam int VX = 0;
`endif
    localparam logic [511:0] VER_OK = 512'h6332307031333035302e3031;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         encdec = 1'b0;
    logic [255:0] key = '0;
    logic [95:0]  nonce = '0;
    logic [511:0] block_in = '0;
    logic         busy, done, err, tag_ok, cs, we;
    logic [511:0] result, write_data;
    logic [127:0] tag;
    logic [7:0]   address;
    logic [511:0] read_data = '0;

    int n_tests = 0;
    int n_fail = 0;

    chacha20_poly1305_bus_master #(.TIMEOUT_POLLS(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .encdec(encdec),
        .key(key), .nonce(nonce), .block_in(block_in),
        .busy(busy), .done(done), .err(err), .result(result), .tag(tag),
        .tag_ok(tag_ok), .cs(cs), .we(we), .address(address),
        .write_data(write_data), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // slave configuration, written only by the stimulus process
    int           s_valid_after = 1;   // 0 = never valid
    bit           s_tagok = 1'b0;
    logic [511:0] s_version = VER_OK;

    // slave state and bus log, written only by the slave process
    logic [31:0]  s_key [8];
    logic [31:0]  s_nonce [3];
    logic         s_enc = 1'b0;
    logic [511:0] s_data = '0;
    int           s_polls = 0;
    logic [7:0]   wa [1024];
    logic [511:0] wd [1024];
    logic [7:0]   ra [1024];
    int           wcnt = 0;
    int           rcnt = 0;
    int           bus_viol = 0;

    // behavioural register slave with registered read data
    always @(posedge clk) begin
        if (reset_n) begin
            if (!cs && (we || write_data != '0)) bus_viol <= bus_viol + 1;
            if (cs && !we && write_data != '0) bus_viol <= bus_viol + 1;
            if (cs && we) begin
                wa[wcnt % 1024] <= address;
                wd[wcnt % 1024] <= write_data;
                wcnt <= wcnt + 1;
                if (address == 8'h0a) s_enc <= write_data[0];
                if (address >= 8'h10 && address <= 8'h17) s_key[address - 8'h10] <= write_data[31:0];
                if (address >= 8'h20 && address <= 8'h22) s_nonce[address - 8'h20] <= write_data[31:0];
                if (address == 8'h30) s_data <= write_data;
                if (address == 8'h08 && write_data[0]) s_polls <= 0;
            end
            if (cs && !we) begin
                ra[rcnt % 1024] <= address;
                rcnt <= rcnt + 1;
                case (address)
                    8'h00: read_data <= s_version;
                    8'h09: begin
                        s_polls <= s_polls + 1;
                        read_data <= {509'b0, s_tagok,
                                      (s_valid_after != 0 && s_polls + 1 >= s_valid_after), 1'b0};
                    end
                    8'h30: read_data <= s_data ^ {2{s_key[0], s_key[1], s_key[2], s_key[3],
                                                    s_key[4], s_key[5], s_key[6], s_key[7]}};
                    8'h40: read_data <= {{384{1'b1}}, s_nonce[2], s_nonce[1], s_nonce[0], 31'b0, s_enc};
                    default: read_data <= '0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [511:0] obs, input logic [511:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // expected state carried between jobs
    logic [511:0] m_result = '0;
    logic [127:0] m_tag = '0;
    logic         m_tagok = 1'b0;

    // One job; called at a negedge with the DUT in IDLE. valid_after=0 means the
    // slave never reports valid; ver_ok=0 means the slave has a wrong version.
    task automatic run_job(input logic [255:0] k, input logic [95:0] n, input logic [511:0] b,
                           input bit ed, input int valid_after, input bit tok,
                           input bit hold, input bit ver_ok);
        logic [7:0]   ea [16];
        logic [511:0] ed_w [16];
        logic [7:0]   er [16];
        int ne, nr, lat, exp_lat, w0, r0, v0, polls, busy_low;
        bit exp_err;
        ne = 0; nr = 0;
        if (VX != 0) begin er[nr] = 8'h00; nr++; end
        if (VX != 0 && !ver_ok) begin
            exp_err = 1'b1;
            exp_lat = 4;
        end else begin
            ea[ne] = 8'h0a; ed_w[ne] = {511'b0, ed}; ne++;
            for (int i = 0; i < 8; i++) begin
                ea[ne] = 8'(8'h10 + i); ed_w[ne] = {480'b0, k[255 - 32*i -: 32]}; ne++;
            end
            for (int i = 0; i < 3; i++) begin
                ea[ne] = 8'(8'h20 + i); ed_w[ne] = {480'b0, n[32*i +: 32]}; ne++;
            end
            ea[ne] = 8'h30; ed_w[ne] = b; ne++;
            ea[ne] = 8'h08; ed_w[ne] = 512'd1; ne++;
            ea[ne] = 8'h08; ed_w[ne] = '0; ne++;
            polls = (valid_after == 0 || valid_after > TMO) ? TMO : valid_after;
            for (int i = 0; i < polls; i++) begin er[nr] = 8'h09; nr++; end
            if (valid_after == 0 || valid_after > TMO) begin
                exp_err = 1'b1;
                exp_lat = 19 + VX + 2*(TMO - 1);
            end else begin
                exp_err = 1'b0;
                exp_lat = 23 + VX + 2*(valid_after - 1);
                er[nr] = 8'h30; nr++;
                er[nr] = 8'h40; nr++;
                m_result = b ^ {k, k};
                m_tag = {n, 31'b0, ed};
                m_tagok = tok;
            end
        end
        s_valid_after = valid_after;
        s_tagok = tok;
        s_version = ver_ok ? VER_OK : 512'h1234;
        w0 = wcnt; r0 = rcnt; v0 = bus_viol;
        key = k; nonce = n; block_in = b; encdec = ed; start = 1'b1;
        @(posedge clk);
        lat = 0; busy_low = 0;
        while (done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (!hold) start = 1'b0;
                key = rnd512()[255:0]; nonce = rnd512()[95:0];
                block_in = rnd512(); encdec = ~ed;
            end
            if (busy !== 1'b1) busy_low++;
        end
        check("latency", 512'(lat), 512'(exp_lat));
        check("busy_held", 512'(busy_low), 512'd0);
        check("err", {511'b0, err}, {511'b0, exp_err});
        check("result", result, m_result);
        check("tag", {384'b0, tag}, {384'b0, m_tag});
        check("tag_ok", {511'b0, tag_ok}, {511'b0, m_tagok});
        @(negedge clk);
        check("idle_gap", {510'b0, busy, done}, '0);
        check("n_writes", 512'(wcnt - w0), 512'(ne));
        for (int i = 0; i < ne && i < wcnt - w0; i++) begin
            check("wr_addr", {504'b0, wa[(w0 + i) % 1024]}, {504'b0, ea[i]});
            check("wr_data", wd[(w0 + i) % 1024], ed_w[i]);
        end
        check("n_reads", 512'(rcnt - r0), 512'(nr));
        for (int i = 0; i < nr && i < rcnt - r0; i++)
            check("rd_addr", {504'b0, ra[(r0 + i) % 1024]}, {504'b0, er[i]});
        check("bus_rules", 512'(bus_viol - v0), 512'd0);
    endtask

    initial begin
        #2;
        check("rst_ctrl", {501'b0, cs, we, busy, done, err, tag_ok, address, 1'b0},'0);
        check("rst_wdata", write_data, '0);
        check("rst_result", result, '0);
        check("rst_tag", {384'b0, tag}, '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // reference vector, valid on first poll
        run_job(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                96'h000000090000004a00000000, rnd512(), 1'b1, 1, 1'b1, 1'b0, 1'b1);
        // valid on the 5th poll
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b0, 5, 1'b0, 1'b0, 1'b1);
        // never valid: timeout, previous results retained
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b1, 0, 1'b1, 1'b0, 1'b1);
        // start held through a job, then a back-to-back job
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b1, 2, 1'b1, 1'b1, 1'b1);
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b0, 1, 1'b0, 1'b0, 1'b1);
        // randomized jobs
        for (int j = 0; j < 8; j++)
            run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'($urandom),
                    int'($urandom_range(0, TMO)), 1'($urandom), (j < 7) ? 1'($urandom) : 1'b0, 1'b1);

        // reset in the middle of the write sequence
        key = rnd512()[255:0]; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", {501'b0, cs, we, busy, done, err, tag_ok, address, 1'b0}, '0);
        check("midrst_wdata", write_data, '0);
        check("midrst_result", result, '0);
        check("midrst_tag", {384'b0, tag}, '0);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_idle", {509'b0, busy, done, cs}, '0);
        end
        m_result = '0; m_tag = '0; m_tagok = 1'b0;
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b1, 3, 1'b1, 1'b0, 1'b1);
`ifdef VERSION_CHECK_EN
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b1, 1, 1'b0, 1'b0, 1'b0);
        run_job(rnd512()[255:0], rnd512()[95:0], rnd512(), 1'b0, 1, 1'b1, 1'b0, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
